// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential radix-2 shift-and-add unsigned multiplier.
// WIDTH x WIDTH -> 2*WIDTH product, one (WIDTH+1)-bit addition per RUN cycle.
// Handshake: start is sampled while not busy, busy is high during RUN and
// done pulses for one cycle when p becomes valid.
// Optional build macro: ZERO_SKIP_EN. When defined, a zero operand bypasses
// RUN and completes with p=0 one cycle after the accepted start.
module shift_add_mult #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t               state, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     h_reg, h_next;
  logic [WIDTH-1:0]     l_reg, l_next;
  logic [CW-1:0]        count, count_next;
  logic [2*WIDTH-1:0]   p_reg, p_next;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     h_shift;
  logic [WIDTH-1:0]     l_shift;
  logic                 start_ok;
  logic                 zero_skip;

  // A start is only honoured outside RUN; DONE accepts it for back-to-back use.
  assign start_ok = start && (state != RUN);

`ifdef ZERO_SKIP_EN
  // Either operand being zero makes the product trivially zero.
  assign zero_skip = (a == '0) || (b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // One shift-and-add step: add the multiplicand to the upper half when the
  // current multiplier bit is set, then shift the whole {S, L} pair right.
  always_comb begin
    sum     = {1'b0, h_reg} + (l_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    h_shift = sum[WIDTH:1];
    l_shift = {sum[0], l_reg[WIDTH-1:1]};
  end

  // Next-state and datapath update; defaults hold every register.
  always_comb begin
    state_next = state;
    a_next     = a_reg;
    h_next     = h_reg;
    l_next     = l_reg;
    count_next = count;
    p_next     = p_reg;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      RUN: begin
        h_next     = h_shift;
        l_next     = l_shift;
        count_next = count + 1'b1;
        if (count == LAST_COUNT) begin
          state_next = DONE;
          p_next     = {h_shift, l_shift};
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (start_ok) begin
      a_next     = a;
      l_next     = b;
      h_next     = '0;
      count_next = '0;
      if (zero_skip) begin
        state_next = DONE;
        p_next     = '0;
      end else begin
        state_next = RUN;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      h_reg <= '0;
      l_reg <= '0;
      count <= '0;
      p_reg <= '0;
    end else begin
      state <= state_next;
      a_reg <= a_next;
      h_reg <= h_next;
      l_reg <= l_next;
      count <= count_next;
      p_reg <= p_next;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign p    = p_reg;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed self-checking bench for shift_add_mult (WIDTH=4).
// Build with +define+ZERO_SKIP_EN to check the zero-operand shortcut.
module tb_shift_add_mult;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [7:0]       p;

  int checks;
  int failures;

  shift_add_mult #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected start-to-done latency for a given operand pair.
  function automatic int exp_latency(input logic [3:0] x, input logic [3:0] y);
`ifdef ZERO_SKIP_EN
    if (x == 4'd0 || y == 4'd0) return 1;
`endif
    return 5;
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With start already driven, step until done is seen. Drops start after
  // the accepting edge. Reports cycles to done and cycles with busy high.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cycles++;
      if (i == 0) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wait_done_timeout: done=%b after %0d cycles, required 1", done, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 4'd15;
    b = 4'd15;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %b, required 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_done: got %b, required 0", done);
    end
    checks++;
    if (p !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_p: got %h, required 00", p);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    a = 4'd15;
    b = 4'd15;
    start = 1'b1;
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d, required 5", cyc);
    end
    checks++;
    if (bcyc !== 4) begin
      failures++;
      $display("[TB] FAIL basic_busy_cycles: got %0d, required 4", bcyc);
    end
    checks++;
    if (p !== 8'hE1) begin
      failures++;
      $display("[TB] FAIL basic_p: got %h, required e1", p);
    end
    a = 4'd2;
    b = 4'd3;
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done_pulse: got %b, required 0", done);
    end
    tick();
    checks++;
    if (p !== 8'hE1) begin
      failures++;
      $display("[TB] FAIL basic_p_hold: got %h, required e1", p);
    end
  endtask

  task automatic test_mixed();
    int cyc, bcyc;
    a = 4'd10;
    b = 4'd3;
    start = 1'b1;
    wait_done(cyc, bcyc);
    checks++;
    if (p !== 8'd30) begin
      failures++;
      $display("[TB] FAIL mixed_p1: got %0d, required 30", p);
    end
    a = 4'd7;
    b = 4'd9;
    start = 1'b1;
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("[TB] FAIL mixed_b2b_latency: got %0d, required 5", cyc);
    end
    checks++;
    if (p !== 8'd63) begin
      failures++;
      $display("[TB] FAIL mixed_p2: got %0d, required 63", p);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int pulses;
    a = 4'd6;
    b = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd15;
    b = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        checks++;
        if (p !== 8'd30) begin
          failures++;
          $display("[TB] FAIL ignored_p: got %0d, required 30", p);
        end
      end
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("[TB] FAIL ignored_pulses: got %0d, required 1", pulses);
    end
  endtask

  task automatic test_zero();
    int cyc, bcyc;
    a = 4'd0;
    b = 4'd9;
    start = 1'b1;
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== exp_latency(4'd0, 4'd9)) begin
      failures++;
      $display("[TB] FAIL zero_a_latency: got %0d, required %0d", cyc, exp_latency(4'd0, 4'd9));
    end
    checks++;
    if (p !== 8'd0) begin
      failures++;
      $display("[TB] FAIL zero_a_p: got %0d, required 0", p);
    end
`ifdef ZERO_SKIP_EN
    checks++;
    if (bcyc !== 0) begin
      failures++;
      $display("[TB] FAIL zero_skip_busy: got %0d busy cycles, required 0", bcyc);
    end
`endif
    tick();
    a = 4'd15;
    b = 4'd0;
    start = 1'b1;
    wait_done(cyc, bcyc);
    checks++;
    if (cyc !== exp_latency(4'd15, 4'd0)) begin
      failures++;
      $display("[TB] FAIL zero_b_latency: got %0d, required %0d", cyc, exp_latency(4'd15, 4'd0));
    end
    checks++;
    if (p !== 8'd0) begin
      failures++;
      $display("[TB] FAIL zero_b_p: got %0d, required 0", p);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc;
    a = 4'd13;
    b = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_busy: got %b, required 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_done: got %b, required 0", done);
    end
    checks++;
    if (p !== 8'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_p: got %0d, required 0", p);
    end
    tick();
    a = 4'd13;
    b = 4'd11;
    start = 1'b1;
    wait_done(cyc, bcyc);
    checks++;
    if (p !== 8'd143) begin
      failures++;
      $display("[TB] FAIL rstmid_rerun_p: got %0d, required 143", p);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    logic [7:0] expected;
    a = 4'd0;
    b = 4'd0;
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = i[7:4];
      b = i[3:0];
      start = 1'b1;
      expected = {4'd0, a} * {4'd0, b};
      wait_done(cyc, bcyc);
      checks++;
      if (p !== expected) begin
        failures++;
        $display("[TB] FAIL b2b_p a=%0d b=%0d: got %0d, required %0d", a, b, p, expected);
      end
      checks++;
      if (cyc !== exp_latency(a, b)) begin
        failures++;
        $display("[TB] FAIL b2b_spacing a=%0d b=%0d: got %0d, required %0d", a, b, cyc, exp_latency(a, b));
      end
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #2;
    test_reset();
    test_basic();
    test_mixed();
    test_ignored_start();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential radix-2 shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Each RUN cycle performs one (WIDTH+1)-bit carry-in-0 addition: upper partial product + multiplicand (or + 0).
- This is the stage that issues operands to, and consumes the sum of, the team's WIDTH-bit prefix adder (default 5-bit sum for WIDTH=4).
- Sits between the operand source and the product sink, with a start/busy/done handshake.

Parameters:
- WIDTH, 4: operand width; the internal adder result is WIDTH+1 bits; the product is 2*WIDTH bits.
- CW, 3: counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk    input   1          rising-edge clock
- rst    input   1          synchronous, active-high reset
- start  input   1          request; sampled only when busy=0
- a      input   WIDTH      multiplicand, captured on accepted start
- b      input   WIDTH      multiplier, captured on accepted start
- busy   output  1          high while in RUN
- done   output  1          one-cycle pulse, product valid
- p      output  2*WIDTH    product; holds until the next accepted start or rst

Behaviour:
- Reset: rst=1 at a clock edge forces state=IDLE, busy=0, done=0, p=0, internal registers=0, count=0. It overrides start and is honoured mid-operation; the partial result is discarded.
- Registers:
  - A (WIDTH): multiplicand
  - H (WIDTH): upper partial product
  - L (WIDTH): multiplier / lower partial product
  - count (CW)
- States: IDLE, RUN, DONE.
- IDLE, or DONE with start=1 (accepted start):
  - A<=a, L<=b, H<=0, count<=0, next state RUN, busy=1.
  - a and b are sampled only at this edge; later changes are ignored.
- RUN, per cycle:
  - S = H + (L[0] ? A : 0), computed as WIDTH+1 bits with carry-in 0, zero-extended.
  - H <= S[WIDTH:1]; L <= {S[0], L[WIDTH-1:1]}; count <= count+1.
  - When count == WIDTH-1: next state DONE, p <= {H_next, L_next}.
- DONE: lasts exactly 1 cycle, done=1, busy=0.
  - start=1 here is accepted (back-to-back: next state RUN).
  - Otherwise next state IDLE. done drops to 0 and p holds.
- start while busy=1 is ignored: no queuing, no effect on the operation in progress.
- Latency: start accepted at edge 0; RUN covers edges 1..WIDTH; done is high during the cycle after edge WIDTH (WIDTH+1 cycles start-to-done, 5 for WIDTH=4).
- Throughput: one product per WIDTH+1 cycles with back-to-back starts.
- Arithmetic: unsigned; the result is always exact; overflow cannot occur (S[WIDTH] is absorbed by the shift).
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Operands of zero or all-ones need no special case in the default build.

Optional Feature:
- Macro: ZERO_SKIP_EN.
- Defined:
  - On an accepted start with a==0 or b==0, the block skips RUN and goes directly to DONE at the next edge with p<=0.
  - done is high in the cycle after the start edge (latency 1); busy stays 0.
- Undefined: zero operands take the full WIDTH RUN cycles and produce p=0.
- Nonzero operands behave identically in both builds.

Test Plan:
- Basic: WIDTH=4, a=15, b=15, start for 1 cycle -> busy high for 4 cycles, done pulse 5 cycles after start, p=8'hE1 (225), p held afterwards.
- Mixed: a=10, b=3 -> p=30. Then a=7, b=9 with start asserted in the done cycle -> second done 5 cycles later, p=63, no idle gap.
- Ignored start: a=6, b=5 accepted; at RUN cycle 2 drive a=15, b=15, start=1 -> p=30, exactly one done pulse.
- Zero operand: a=0, b=9 -> p=0, done 5 cycles after start without ZERO_SKIP_EN and 1 cycle after start with it defined.
- Reset mid-operation: a=13, b=11, assert rst in RUN cycle 2 -> next cycle busy=0, done=0, p=0. A subsequent start with a=13, b=11 gives p=143.
- Exhaustive: all 256 (a,b) pairs for WIDTH=4, back-to-back -> p == a*b each time, done pulse spacing 5 cycles.
